model1_ctrl: RTL and testbench

MODEL1_CTRL -- requirements
Module: model1_ctrl

---
 rtl/sz_ctrl_pkg.sv | 20 ++
 rtl/sz_sync_fifo.sv | 50 +++++
 rtl/model1_ctrl.sv | 147 ++++++++++++++
 tb/tb_model1_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sz_ctrl_pkg.sv
// Shared widths, latencies, FSM encoding and the error-bound hit test for the predictor controller.
package sz_ctrl_pkg;

  localparam int DW         = 32;
  localparam int ERR_LAT    = 24;
  localparam int PRED_LAT   = 12;
  localparam int FIFO_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // NaN/Inf magnitudes never count as a hit, whatever the bound.
  function automatic logic err_hit(input logic [30:0] abs_err, input logic [30:0] bound);
    return (abs_err[30:23] != 8'hFF) && (abs_err <= bound);
  endfunction

endpackage

// File: rtl/sz_sync_fifo.sv
// Synchronous FIFO with occupancy count; a full FIFO still accepts a push in a popping cycle.
module sz_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/model1_ctrl.sv
// Block controller around an external first-order predictor: feeds samples with n-1/n-2 history,
// tags them through the predictor latency and buffers {pred, err, hit, last}; input is credit-throttled.
module model1_ctrl #(
  parameter int DW         = sz_ctrl_pkg::DW,
  parameter int ERR_LAT    = sz_ctrl_pkg::ERR_LAT,
  parameter int PRED_LAT   = sz_ctrl_pkg::PRED_LAT,
  parameter int FIFO_DEPTH = sz_ctrl_pkg::FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [15:0]   blk_len,
  input  logic [30:0]   err_bound,
  output logic          busy,
  output logic          done,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] p_data_in,
  output logic [DW-1:0] p_proceed1,
  output logic [DW-1:0] p_proceed2,
  input  logic [DW-1:0] p_pred,
  input  logic [DW-1:0] p_real_err,
  input  logic [DW-1:0] p_abs_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_pred,
  output logic [DW-1:0] out_err,
  output logic          out_hit,
  output logic          out_last
);

  import sz_ctrl_pkg::*;

  localparam int PD = ERR_LAT - PRED_LAT;
  localparam int LW = $clog2(ERR_LAT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int FW = 2 * DW + 2;

  state_t             state, state_nxt;
  logic [15:0]        len_q, idx_q;
  logic [ERR_LAT-1:0] tag_vld, tag_last;
  logic [LW-1:0]      inflight;
  logic [CW-1:0]      fifo_cnt;
  logic [OW-1:0]      outstanding;
  logic               xfer, is_last, tag_exit, pop, fifo_empty;
  logic               fifo_full_unused, abs_sign_unused;
  logic [DW-1:0]      pred_dly [PD];
  logic [FW-1:0]      push_dat, head_dat;

  // Every accepted sample owns a FIFO slot until popped, so the buffer cannot overflow.
  assign outstanding = OW'(inflight) + OW'(fifo_cnt);
  assign in_ready    = (state == RUN) && (outstanding < OW'(FIFO_DEPTH));
  assign xfer        = in_valid & in_ready;
  assign is_last     = (idx_q == len_q - 16'd1);
  assign busy        = (state != IDLE);
  assign tag_exit    = tag_vld[ERR_LAT-1];

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:    if (start && blk_len != 16'd0) state_nxt = RUN;
      RUN:     if (xfer && is_last) state_nxt = DRAIN;
      DRAIN: begin
        if (inflight == '0 && fifo_cnt == '0) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      p_data_in  <= '0;
      p_proceed1 <= '0;
      p_proceed2 <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && blk_len != 16'd0) begin
        len_q <= blk_len;
        idx_q <= '0;
      end
      if (xfer) begin
        idx_q      <= idx_q + 16'd1;
        p_data_in  <= in_data;
        p_proceed2 <= (idx_q == 16'd0) ? '0 : p_data_in;
        p_proceed1 <= (idx_q < 16'd2) ? '0 : p_proceed2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_last <= '0;
      inflight <= '0;
    end else begin
      tag_vld  <= {tag_vld[ERR_LAT-2:0], xfer};
      tag_last <= {tag_last[ERR_LAT-2:0], xfer & is_last};
      inflight <= inflight + LW'(xfer) - LW'(tag_exit);
    end
  end

  // Prediction is ready earlier than the error; delay it so both describe the same sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PD; i++) pred_dly[i] <= '0;
    end else begin
      pred_dly[0] <= p_pred;
      for (int i = 1; i < PD; i++) pred_dly[i] <= pred_dly[i-1];
    end
  end

  assign abs_sign_unused = p_abs_err[DW-1];
  assign push_dat = {pred_dly[PD-1], p_real_err, err_hit(p_abs_err[30:0], err_bound),
                     tag_last[ERR_LAT-1]};

  sz_sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tag_exit),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (head_dat),
    .count    (fifo_cnt),
    .empty    (fifo_empty),
    .full     (fifo_full_unused)
  );

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign out_pred  = out_valid ? head_dat[FW-1:DW+2] : '0;
  assign out_err   = out_valid ? head_dat[DW+1:2] : '0;
  assign out_hit   = out_valid & head_dat[1];
  assign out_last  = out_valid & head_dat[0];

endmodule

// File: tb/tb_model1_ctrl.sv
// Bench for model1_ctrl: stand-in predictor, queue-based reference model checked every cycle, directed literal pins.
module tb_model1_ctrl;

  localparam int ERR_LAT  = 24;
  localparam int PRED_LAT = 12;
  localparam int DEPTH    = 32;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic [15:0] blk_len;
  logic [30:0] err_bound;
  logic        in_valid, in_ready, out_valid, out_ready, out_hit, out_last;
  logic [31:0] in_data, p_data_in, p_proceed1, p_proceed2, p_pred, p_real_err, p_abs_err;
  logic [31:0] out_pred, out_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  model1_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .blk_len(blk_len), .err_bound(err_bound),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .p_data_in(p_data_in), .p_proceed1(p_proceed1), .p_proceed2(p_proceed2),
    .p_pred(p_pred), .p_real_err(p_real_err), .p_abs_err(p_abs_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pred(out_pred), .out_err(out_err),
    .out_hit(out_hit), .out_last(out_last)
  );

  // Stand-in predictor: pred = 2*x[n-1] - x[n-2], err = x - pred, |err| taken as x with sign cleared.
  logic [31:0] pp [PRED_LAT-1];
  logic [31:0] pe [ERR_LAT-1];
  logic [31:0] pa [ERR_LAT-1];
  always @(posedge clk) begin
    pp[0] <= (p_proceed2 << 1) - p_proceed1;
    pe[0] <= p_data_in - ((p_proceed2 << 1) - p_proceed1);
    pa[0] <= {1'b0, p_data_in[30:0]};
    for (int i = 1; i < PRED_LAT - 1; i++) pp[i] <= pp[i-1];
    for (int i = 1; i < ERR_LAT - 1; i++) begin
      pe[i] <= pe[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign p_pred     = pp[PRED_LAT-2];
  assign p_real_err = pe[ERR_LAT-2];
  assign p_abs_err  = pa[ERR_LAT-2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus driver ----------------
  int          in_mode = 0, out_mode = 0, xfer_cnt = 0;
  logic [31:0] dir_q [$];

  function automatic logic [31:0] rnd_sample();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) == 0) r[30:23] = 8'hFF;
    return r;
  endfunction

  initial begin : drive
    logic took;
    forever begin
      @(negedge clk);
      took = in_valid && in_ready && !rst;
      @(posedge clk);
      #1;
      if (took) begin
        xfer_cnt++;
        if (in_mode == 3 && dir_q.size() != 0) dir_q.delete(0);
      end
      case (in_mode)
        0: in_valid = 1'b0;
        1: begin in_valid = 1'b1; in_data = rnd_sample(); end
        2: begin in_valid = 1'($urandom_range(0, 1)); in_data = rnd_sample(); end
        default: begin
          in_valid = (dir_q.size() != 0);
          in_data  = (dir_q.size() != 0) ? dir_q[0] : 32'h0;
        end
      endcase
      case (out_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        2: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct {
    logic [31:0] pred;
    logic [31:0] err;
    logic        hit;
    logic        last;
    int          edge_no;
  } exp_t;

  exp_t        eq [$];
  logic [31:0] bs [$];
  logic [63:0] prox_log [$];
  logic        hit_log [$];
  logic        last_log [$];
  int          done_neg = -1, last_pop_neg = -1;

  initial begin : model
    bit          active, just_acc, ev, ed, er;
    int          mlen, acc, popd;
    logic [31:0] exp_din, exp_p1, exp_p2, x, p1, p2, pr;
    exp_t        e;
    active = 0; just_acc = 0; mlen = 0; acc = 0; popd = 0;
    exp_din = 0; exp_p1 = 0; exp_p2 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        eq.delete(); bs.delete();
        active = 0; just_acc = 0; acc = 0; popd = 0;
        exp_din = 0; exp_p1 = 0; exp_p2 = 0;
      end else begin
        ev = (eq.size() != 0) && (eq[0].edge_no + ERR_LAT <= cyc);
        ed = active && (acc == mlen) && (popd == mlen);
        er = active && (acc < mlen) && ((acc - popd) < DEPTH);
        chk("busy", busy, active);
        chk("done", done, ed);
        chk("in_ready", in_ready, er);
        chk("out_valid", out_valid, ev);
        if (ev && out_valid) begin
          chk("out_pred", out_pred, eq[0].pred);
          chk("out_err", out_err, eq[0].err);
          chk("out_hit", out_hit, eq[0].hit);
          chk("out_last", out_last, eq[0].last);
        end
        chk("p_data_in", p_data_in, exp_din);
        chk("p_proceed1", p_proceed1, exp_p1);
        chk("p_proceed2", p_proceed2, exp_p2);
        if (just_acc) prox_log.push_back({p_proceed1, p_proceed2});
        just_acc = 0;
        if (done) done_neg = cyc;

        if (ed) active = 0;
        else if (start && !active && blk_len != 16'd0) begin
          active = 1; mlen = blk_len; acc = 0; popd = 0; bs.delete();
        end
        if (er && in_valid) begin
          x  = in_data;
          p2 = (acc >= 1) ? bs[acc-1] : 32'h0;
          p1 = (acc >= 2) ? bs[acc-2] : 32'h0;
          pr = (p2 << 1) - p1;
          e.pred    = pr;
          e.err     = x - pr;
          e.hit     = (x[30:23] != 8'hFF) && (x[30:0] <= err_bound);
          e.last    = (acc == mlen - 1);
          e.edge_no = cyc + 1;
          eq.push_back(e);
          bs.push_back(x);
          exp_din = x; exp_p1 = p1; exp_p2 = p2;
          acc++;
          just_acc = 1;
        end
        if (ev && out_ready) begin
          hit_log.push_back(out_hit);
          last_log.push_back(out_last);
          last_pop_neg = cyc;
          eq.delete(0);
          popd++;
        end
      end
    end
  end

  // ---------------- directed / randomized sequence ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start_blk(input logic [15:0] len);
    blk_len = len;
    start   = 1'b1;
    tick(1);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk(name, busy, 1'b0);
  endtask

  task automatic clear_logs();
    prox_log.delete(); hit_log.delete(); last_log.delete();
    xfer_cnt = 0; done_neg = -1; last_pop_neg = -1;
  endtask

  logic [63:0] prox_026 [4] = '{64'h0, {32'h0, 32'h3F800000},
                                {32'h3F800000, 32'h40000000}, {32'h40000000, 32'h40400000}};
  logic        hits_027 [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin : main
    rst = 1'b1; start = 1'b0; blk_len = '0; err_bound = 31'h3F000000;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_done", done, 1'b0);

    // zero-length start is ignored
    start_blk(16'd0);
    tick(1);
    chk("len0_ignored", busy, 1'b0);

    // four-sample block, plus a start pulse while running
    clear_logs();
    out_mode = 1;
    dir_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    in_mode = 3;
    start_blk(16'd4);
    tick(2);
    start_blk(16'd7);
    wait_idle(200, "blk4_timeout");
    chk("blk4_nprox", prox_log.size(), 4);
    chk("blk4_nout", hit_log.size(), 4);
    for (int i = 0; i < 4 && i < prox_log.size(); i++) chk("blk4_proceed", prox_log[i], prox_026[i]);
    for (int i = 0; i < 4 && i < last_log.size(); i++) chk("blk4_last", last_log[i], i == 3);
    chk("blk4_done_timing", done_neg, last_pop_neg + 1);

    // hit rule against 0.5
    clear_logs();
    dir_q = '{32'h3E800000, 32'h3F800000, 32'h7FC00000, 32'h3F000000, 32'hBF000000};
    start_blk(16'd5);
    wait_idle(200, "hit_timeout");
    chk("hit_nout", hit_log.size(), 5);
    for (int i = 0; i < 5 && i < hit_log.size(); i++) chk("hit_lit", hit_log[i], hits_027[i]);

    // credit stop with sink stalled
    clear_logs();
    err_bound = 31'($urandom);
    in_mode = 1; out_mode = 0;
    start_blk(16'd40);
    tick(80);
    chk("credit_stop_count", xfer_cnt, 32);
    chk("credit_stop_ready", in_ready, 1'b0);
    out_mode = 1;
    wait_idle(600, "credit_timeout");
    chk("credit_nout", hit_log.size(), 40);
    if (last_log.size() == 40) chk("credit_last", last_log[39], 1'b1);

    // toggling sink, random source
    clear_logs();
    in_mode = 2; out_mode = 2;
    start_blk(16'd60);
    wait_idle(3000, "toggle_timeout");
    chk("toggle_nout", hit_log.size(), 60);

    // random blocks
    for (int b = 0; b < 4; b++) begin
      int len;
      clear_logs();
      len = $urandom_range(1, 50);
      err_bound = (b % 2 == 0) ? 31'($urandom) : 31'h3F000000;
      in_mode = 2; out_mode = 3;
      start_blk(16'(len));
      wait_idle(4000, "rand_timeout");
      chk("rand_nout", hit_log.size(), len);
    end

    // reset in the middle of a block, then a clean block
    clear_logs();
    in_mode = 1; out_mode = 1;
    start_blk(16'd10);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_done", done, 1'b0);
    dir_q = '{32'h40A00000, 32'h40C00000};
    in_mode = 3;
    tick(1);
    clear_logs();
    start_blk(16'd2);
    wait_idle(200, "post_rst_timeout");
    chk("post_rst_nprox", prox_log.size(), 2);
    if (prox_log.size() == 2) begin
      chk("post_rst_hist0", prox_log[0], 64'h0);
      chk("post_rst_hist1", prox_log[1], {32'h0, 32'h40A00000});
    end
    chk("post_rst_nout", hit_log.size(), 2);

    in_mode = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
